// File: rtl/bcd_year_counter_if.sv
// Strobe/data bundle between the calendar chain and the BCD year counter.
// The master drives the strobes and load value; the slave returns the year and its flags.
interface bcd_year_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en_yr;
  logic                  up;
  logic                  down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   year;
  logic                  leap_year;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output en_yr, up, down, load, load_val,
    input  year, leap_year, wrap, load_err
  );

  modport slave (
    input  en_yr, up, down, load, load_val,
    output year, leap_year, wrap, load_err
  );
endinterface

// File: rtl/bcd_year_counter.sv
// Packed-BCD year counter with load, manual adjust, Gregorian leap flag and
// wrap/saturate handling at the ends of the 0 .. 10^DIGITS-1 range.
module bcd_year_counter #(
  parameter int          DIGITS     = 4,
  parameter logic [31:0] RESET_YEAR = 32'h0000_2000,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  bcd_year_counter_if.slave  bus
);

  localparam int             W         = 4 * DIGITS;
  localparam logic [W-1:0]   RESET_VAL = RESET_YEAR[W-1:0];
  localparam logic [W-1:0]   ALL_NINES = {DIGITS{4'h9}};
  localparam logic [W-1:0]   ALL_ZERO  = {W{1'b0}};

  logic [W-1:0] year_r;
  logic         wrap_r;
  logic         load_err_r;
  logic [W-1:0] year_nxt_s;
  logic         wrap_nxt_s;
  logic         load_err_nxt_s;
  logic         inc_req_s;
  logic         dec_req_s;
  logic         leap_s;

  function automatic logic all_digits_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & (v[4*i +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A two-digit BCD number is a multiple of 4 iff the units digit fits the tens parity.
  function automatic logic bcd2_div4(input logic [3:0] tens, input logic [3:0] units);
    logic res;
    if (tens[0] == 1'b0) begin
      res = (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    end else begin
      res = (units == 4'd2) || (units == 4'd6);
    end
    return res;
  endfunction

  assign inc_req_s = bus.en_yr || (bus.up && !bus.down);
  assign dec_req_s = !bus.en_yr && bus.down && !bus.up;

  // Century years fall back to the thousands:hundreds pair; only the low four digits matter.
  assign leap_s = (year_r[7:0] == 8'h00) ? bcd2_div4(year_r[15:12], year_r[11:8])
                                         : bcd2_div4(year_r[7:4], year_r[3:0]);

  // Next-state selection in priority order: load, increment, decrement, hold.
  always_comb begin
    year_nxt_s     = year_r;
    wrap_nxt_s     = 1'b0;
    load_err_nxt_s = 1'b0;
    if (bus.load) begin
      if (all_digits_valid(bus.load_val)) begin
        year_nxt_s = bus.load_val;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (inc_req_s) begin
      if (year_r == ALL_NINES) begin
        wrap_nxt_s = 1'b1;
        year_nxt_s = SATURATE ? year_r : ALL_ZERO;
      end else begin
        year_nxt_s = bcd_inc(year_r);
      end
    end else if (dec_req_s) begin
      if (year_r == ALL_ZERO) begin
        wrap_nxt_s = 1'b1;
        year_nxt_s = SATURATE ? year_r : ALL_NINES;
      end else begin
        year_nxt_s = bcd_dec(year_r);
      end
    end else begin
      year_nxt_s = year_r;
    end
  end

  // State and pulse registers; an asynchronous reset drops any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year_r     <= RESET_VAL;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      year_r     <= year_nxt_s;
      wrap_r     <= wrap_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign bus.year      = year_r;
  assign bus.leap_year = leap_s;
  assign bus.wrap      = wrap_r;
  assign bus.load_err  = load_err_r;

endmodule

// File: tb/tb_bcd_year_counter.sv
// Scoreboard bench for bcd_year_counter: a wrapping and a saturating instance,
// directed vectors with hand-computed expectations checked by a negedge monitor.
module tb_bcd_year_counter;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int          sel;
    int          cyc;
    logic [15:0] year;
    logic        leap;
    logic        wrap;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  bcd_year_counter_if #(.DIGITS(4)) bus0 ();
  bcd_year_counter_if #(.DIGITS(4)) bus1 ();

  bcd_year_counter #(.DIGITS(4), .RESET_YEAR(32'h0000_2000), .SATURATE(1'b0)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bcd_year_counter #(.DIGITS(4), .RESET_YEAR(32'h0000_2000), .SATURATE(1'b1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string nm, input logic [15:0] ay, input logic al, input logic aw,
                         input logic ae, input logic [15:0] ey, input logic el, input logic ew,
                         input logic ee);
    checks = checks + 1;
    if ({ay, al, aw, ae} !== {ey, el, ew, ee}) begin
      errors = errors + 1;
      $display("FAIL %s: got year=%h leap=%b wrap=%b load_err=%b, expected year=%h leap=%b wrap=%b load_err=%b",
               nm, ay, al, aw, ae, ey, el, ew, ee);
    end
  endtask

  // Monitor: pops every expectation due on this cycle and compares it with the chosen DUT.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      cur = q.pop_front();
      if (cur.sel == 0)
        compare(cur.name, bus0.year, bus0.leap_year, bus0.wrap, bus0.load_err,
                cur.year, cur.leap, cur.wrap, cur.err);
      else
        compare(cur.name, bus1.year, bus1.leap_year, bus1.wrap, bus1.load_err,
                cur.year, cur.leap, cur.wrap, cur.err);
    end
  end

  task automatic idle_all();
    bus0.en_yr = 1'b0; bus0.up = 1'b0; bus0.down = 1'b0; bus0.load = 1'b0; bus0.load_val = 16'h0000;
    bus1.en_yr = 1'b0; bus1.up = 1'b0; bus1.down = 1'b0; bus1.load = 1'b0; bus1.load_val = 16'h0000;
  endtask

  task automatic push_exp(input int sel, input logic [15:0] ey, input logic el, input logic ew,
                          input logic ee, input string nm);
    exp_t e;
    e.sel  = sel;
    e.cyc  = cyc + 1;
    e.year = ey;
    e.leap = el;
    e.wrap = ew;
    e.err  = ee;
    e.name = nm;
    q.push_back(e);
  endtask

  // One clock of stimulus on DUT sel, with the expected state after that edge.
  task automatic step(input int sel, input logic en, input logic u, input logic d, input logic l,
                      input logic [15:0] lv, input logic [15:0] ey, input logic el,
                      input logic ew, input logic ee, input string nm);
    @(negedge clk);
    idle_all();
    if (sel == 0) begin
      bus0.en_yr = en; bus0.up = u; bus0.down = d; bus0.load = l; bus0.load_val = lv;
    end else begin
      bus1.en_yr = en; bus1.up = u; bus1.down = d; bus1.load = l; bus1.load_val = lv;
    end
    push_exp(sel, ey, el, ew, ee, nm);
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //    sel en u  d  ld  load_val  year     leap wrap err
    step(0, 0, 0, 0, 0, 16'h0000, 16'h2000, 1, 0, 0, "reset_idle");
    step(0, 1, 0, 0, 0, 16'h0000, 16'h2001, 0, 0, 0, "en_2001");
    step(0, 0, 1, 0, 0, 16'h0000, 16'h2002, 0, 0, 0, "up_2002");
    step(0, 0, 1, 0, 0, 16'h0000, 16'h2003, 0, 0, 0, "up_2003");
    step(0, 0, 1, 0, 0, 16'h0000, 16'h2004, 1, 0, 0, "up_2004");
    step(0, 0, 0, 0, 1, 16'h1899, 16'h1899, 0, 0, 0, "load_1899");
    step(0, 1, 0, 0, 0, 16'h0000, 16'h1900, 0, 0, 0, "en_1900");
    step(0, 0, 0, 0, 1, 16'h2399, 16'h2399, 0, 0, 0, "load_2399");
    step(0, 1, 0, 0, 0, 16'h0000, 16'h2400, 1, 0, 0, "en_2400");
    step(0, 0, 0, 0, 1, 16'h2100, 16'h2100, 0, 0, 0, "load_2100");
    step(0, 0, 0, 0, 1, 16'h1996, 16'h1996, 1, 0, 0, "load_1996");
    step(0, 0, 0, 0, 1, 16'h2000, 16'h2000, 1, 0, 0, "load_2000");
    step(0, 0, 0, 1, 0, 16'h0000, 16'h1999, 0, 0, 0, "down_borrow_1999");
    step(0, 0, 0, 0, 1, 16'h9999, 16'h9999, 0, 0, 0, "load_9999");
    step(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, "en_wrap_0000");
    step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "wrap_one_cycle");
    step(0, 0, 0, 1, 0, 16'h0000, 16'h9999, 0, 1, 0, "down_wrap_9999");
    step(0, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0, "wrap2_one_cycle");
    step(0, 1, 1, 0, 1, 16'h2024, 16'h2024, 1, 0, 0, "prio_load");
    step(0, 1, 0, 1, 0, 16'h0000, 16'h2025, 0, 0, 0, "prio_en_over_down");
    step(0, 0, 1, 1, 0, 16'h0000, 16'h2025, 0, 0, 0, "up_down_hold");
    step(0, 0, 0, 0, 1, 16'h20A5, 16'h2025, 0, 0, 1, "load_bad_20a5");
    step(0, 0, 0, 0, 0, 16'h0000, 16'h2025, 0, 0, 0, "load_err_one_cycle");
    step(0, 0, 0, 0, 1, 16'h3457, 16'h3457, 0, 0, 0, "load_3457");
    step(0, 0, 0, 0, 1, 16'hF000, 16'h3457, 0, 0, 1, "load_bad_pending");

    // Mid-cycle asynchronous reset while a load_err pulse is showing.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 compare("async_reset", bus0.year, bus0.leap_year, bus0.wrap, bus0.load_err,
               16'h2000, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b0;
    bus0.en_yr = 1'b1;
    push_exp(0, 16'h2001, 1'b0, 1'b0, 1'b0, "first_edge_after_reset");
    @(posedge clk);
    #1 idle_all();

    step(1, 0, 0, 0, 0, 16'h0000, 16'h2000, 1, 0, 0, "sat_reset_idle");
    step(1, 0, 0, 0, 1, 16'h9999, 16'h9999, 0, 0, 0, "sat_load_9999");
    step(1, 0, 1, 0, 0, 16'h0000, 16'h9999, 0, 1, 0, "sat_up_hold");
    step(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0, "sat_wrap_one_cycle");
    step(1, 1, 0, 0, 0, 16'h0000, 16'h9999, 0, 1, 0, "sat_en_hold");
    step(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, "sat_load_0000");
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, "sat_down_hold");
    step(1, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, "sat_up_0001");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
